// File: rtl/shift_register_pipe_pkg.sv
// Shared constants and helpers for the shift_register_pipe delay line.
package shift_register_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    function automatic int fill_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shift_register_pipe_stage.sv
// One data+valid register of the pipe: CE shifts, CLR and reset load INIT.
module shift_register_pipe_stage #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             CE,
    input  logic             CLR,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            q       <= INIT;
            q_valid <= 1'b0;
        end else if (CLR) begin
            q       <= INIT;
            q_valid <= 1'b0;
        end else if (CE) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/shift_register_pipe.sv
// Enable-gated WIDTH x DEPTH delay line with valid tracking and fill count.
// Define SHIFT_REGISTER_PIPE_TAPS_EN to expose every stage on taps/tap_valid.
module shift_register_pipe
    import shift_register_pipe_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter int               DEPTH = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                             CLK,
    input  logic                             ASYNCRESET,
    input  logic                             CE,
    input  logic                             CLR,
    input  logic [WIDTH-1:0]                 I,
    input  logic                             I_valid,
    output logic [WIDTH-1:0]                 O,
    output logic                             O_valid,
    output logic [fill_width(DEPTH)-1:0]     fill,
    output logic                             full
`ifdef SHIFT_REGISTER_PIPE_TAPS_EN
    ,
    output logic [DEPTH*WIDTH-1:0]           taps,
    output logic [DEPTH-1:0]                 tap_valid
`endif
);

    localparam int FW = fill_width(DEPTH);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_n;
    logic             full_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            shift_register_pipe_stage #(
                .WIDTH (WIDTH),
                .INIT  (INIT)
            ) u_stage (
                .CLK        (CLK),
                .ASYNCRESET (ASYNCRESET),
                .CE         (CE),
                .CLR        (CLR),
                .d          (I),
                .d_valid    (I_valid),
                .q          (data[k]),
                .q_valid    (vld[k])
            );
        end else begin : g_body
            shift_register_pipe_stage #(
                .WIDTH (WIDTH),
                .INIT  (INIT)
            ) u_stage (
                .CLK        (CLK),
                .ASYNCRESET (ASYNCRESET),
                .CE         (CE),
                .CLR        (CLR),
                .d          (data[k-1]),
                .d_valid    (vld[k-1]),
                .q          (data[k]),
                .q_valid    (vld[k])
            );
        end
`ifdef SHIFT_REGISTER_PIPE_TAPS_EN
        assign taps[k*WIDTH +: WIDTH] = data[k];
`endif
    end

`ifdef SHIFT_REGISTER_PIPE_TAPS_EN
    assign tap_valid = vld;
`endif

    // Incremental count: one in and one out in the same cycle leaves it unchanged.
    always_comb begin
        fill_n = fill_q;
        if (I_valid && !vld[DEPTH-1]) begin
            fill_n = fill_q + FW'(1);
        end else if (!I_valid && vld[DEPTH-1]) begin
            fill_n = fill_q - FW'(1);
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            fill_q <= '0;
            full_q <= 1'b0;
        end else if (CLR) begin
            fill_q <= '0;
            full_q <= 1'b0;
        end else if (CE) begin
            fill_q <= fill_n;
            full_q <= (fill_n == FW'(DEPTH));
        end
    end

    assign O       = data[DEPTH-1];
    assign O_valid = vld[DEPTH-1];
    assign fill    = fill_q;
    assign full    = full_q;

endmodule

// File: tb/tb_shift_register_pipe.sv
// Scoreboard bench for shift_register_pipe (DEPTH=4 main, DEPTH=1 side).
module tb_shift_register_pipe;

    localparam logic [7:0] INIT_V = 8'hA5;

    logic       CLK;
    logic       ASYNCRESET;
    logic       CE;
    logic       CLR;
    logic [7:0] I;
    logic       I_valid;
    logic [7:0] O;
    logic       O_valid;
    logic [2:0] fill;
    logic       full;
    logic [7:0] o1;
    logic       o1_valid;
    logic [0:0] fill1;
    logic       full1;
`ifdef SHIFT_REGISTER_PIPE_TAPS_EN
    logic [31:0] taps;
    logic [3:0]  tap_valid;
    logic [7:0]  taps1;
    logic [0:0]  tap_valid1;
`endif

    shift_register_pipe #(.WIDTH(8), .DEPTH(4), .INIT(INIT_V)) dut (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .CE(CE), .CLR(CLR),
        .I(I), .I_valid(I_valid), .O(O), .O_valid(O_valid),
        .fill(fill), .full(full)
`ifdef SHIFT_REGISTER_PIPE_TAPS_EN
        , .taps(taps), .tap_valid(tap_valid)
`endif
    );

    shift_register_pipe #(.WIDTH(8), .DEPTH(1), .INIT(INIT_V)) dut1 (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .CE(CE), .CLR(CLR),
        .I(I), .I_valid(I_valid), .O(o1), .O_valid(o1_valid),
        .fill(fill1), .full(full1)
`ifdef SHIFT_REGISTER_PIPE_TAPS_EN
        , .taps(taps1), .tap_valid(tap_valid1)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    logic [3:0] mvld = '0;
    logic [7:0] exp_o = INIT_V;

    // Drive one edge and advance the scoreboard; no comparisons here.
    task automatic drive(input logic ce, input logic clr,
                         input logic iv, input logic [7:0] d);
        CE = ce; CLR = clr; I_valid = iv; I = d;
        @(posedge CLK);
        if (clr) begin
            mvld = '0;
            exp_q.delete();
            exp_o = INIT_V;
        end else if (ce) begin
            if (iv) exp_q.push_back(d);
            mvld = {mvld[2:0], iv};
            if (mvld[3]) exp_o = exp_q.pop_front();
        end
        #1;
        CE = 1'b0; CLR = 1'b0; I_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (O !== INIT_V || O_valid !== 1'b0 || fill !== 3'd0 || full !== 1'b0) begin
            bad++;
            $display("FAIL reset_init: O=%h v=%b fill=%0d full=%b want A5/0/0/0",
                     O, O_valid, fill, full);
        end
        ASYNCRESET = 1'b0;
        drive(1, 0, 1, 8'h11);
        drive(1, 0, 1, 8'h22);
        #3;
        ASYNCRESET = 1'b1;
        #1;
        total++;
        if (O !== INIT_V || O_valid !== 1'b0 || fill !== 3'd0 || full !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: O=%h v=%b fill=%0d full=%b want A5/0/0/0",
                     O, O_valid, fill, full);
        end
        #1;
        ASYNCRESET = 1'b0;
        mvld = '0;
        exp_q.delete();
        exp_o = INIT_V;
    endtask

    task automatic test_latency();
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, i < 5, 8'(i + 1));
            total++;
            if (O_valid !== mvld[3] || fill !== 3'($countones(mvld))
                || full !== (&mvld)) begin
                bad++;
                $display("FAIL latency_ctl[%0d]: v=%b fill=%0d full=%b want %b/%0d/%b",
                         i, O_valid, fill, full, mvld[3], $countones(mvld), &mvld);
            end
            if (mvld[3]) begin
                total++;
                if (O !== exp_o) begin
                    bad++;
                    $display("FAIL latency_data[%0d]: O=%h want %h", i, O, exp_o);
                end
            end
        end
        total++;
        if (O_valid !== 1'b0 || fill !== 3'd0) begin
            bad++;
            $display("FAIL latency_drain: v=%b fill=%0d want 0/0", O_valid, fill);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 11; i++) begin
            if (i < 4) drive(1, 0, 1, 8'(i + 1));
            else if (i < 7) drive(0, 0, 1, 8'h99);
            else drive(1, 0, 0, 8'h00);
            total++;
            if (O_valid !== mvld[3] || fill !== 3'($countones(mvld))
                || full !== (&mvld)) begin
                bad++;
                $display("FAIL stall_ctl[%0d]: v=%b fill=%0d full=%b want %b/%0d/%b",
                         i, O_valid, fill, full, mvld[3], $countones(mvld), &mvld);
            end
            if (mvld[3]) begin
                total++;
                if (O !== exp_o) begin
                    bad++;
                    $display("FAIL stall_data[%0d]: O=%h want %h", i, O, exp_o);
                end
            end
        end
        total++;
        if (exp_q.size() != 0 || fill !== 3'd0) begin
            bad++;
            $display("FAIL stall_leftover: queue=%0d fill=%0d want 0/0",
                     exp_q.size(), fill);
        end
    endtask

    task automatic test_bubbles();
        logic [7:0] pat;
        int         peak;
        pat = 8'b0000_0101;
        peak = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, pat[i], 8'h40 + 8'(i));
            if (int'(fill) > peak) peak = int'(fill);
            total++;
            if (O_valid !== mvld[3] || fill !== 3'($countones(mvld))) begin
                bad++;
                $display("FAIL bubble_ctl[%0d]: v=%b fill=%0d want %b/%0d",
                         i, O_valid, fill, mvld[3], $countones(mvld));
            end
            if (mvld[3]) begin
                total++;
                if (O !== exp_o) begin
                    bad++;
                    $display("FAIL bubble_data[%0d]: O=%h want %h", i, O, exp_o);
                end
            end
        end
        total++;
        if (peak != 2) begin
            bad++;
            $display("FAIL bubble_peak: got %0d want 2", peak);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 8'h60 + 8'(i));
        total++;
        if (fill !== 3'd3) begin
            bad++;
            $display("FAIL clear_pre: fill=%0d want 3", fill);
        end
        drive(1, 1, 1, 8'h77);
        total++;
        if (fill !== 3'd0 || O !== INIT_V || O_valid !== 1'b0 || full !== 1'b0) begin
            bad++;
            $display("FAIL clear_now: fill=%0d O=%h v=%b full=%b want 0/A5/0/0",
                     fill, O, O_valid, full);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 8'h88);
            total++;
            if (O_valid !== 1'b0 || fill !== 3'd0) begin
                bad++;
                $display("FAIL clear_after[%0d]: v=%b fill=%0d want 0/0",
                         i, O_valid, fill);
            end
        end
    endtask

    task automatic test_depth1();
        logic iv;
        logic [7:0] d;
        for (int i = 0; i < 6; i++) begin
            iv = (i % 2 == 0);
            d = 8'hC0 + 8'(i);
            drive(1, 0, iv, d);
            total++;
            if (o1 !== d || o1_valid !== iv || fill1 !== iv || full1 !== iv) begin
                bad++;
                $display("FAIL depth1[%0d]: O=%h v=%b fill=%0d full=%b want %h/%b/%0d/%b",
                         i, o1, o1_valid, fill1, full1, d, iv, iv, iv);
            end
`ifdef SHIFT_REGISTER_PIPE_TAPS_EN
            total++;
            if (taps1 !== d || tap_valid1 !== iv) begin
                bad++;
                $display("FAIL depth1_taps[%0d]: taps=%h tv=%b want %h/%b",
                         i, taps1, tap_valid1, d, iv);
            end
`endif
        end
        drive(0, 0, 1, 8'hEE);
        total++;
        if (o1 !== 8'hC5 || o1_valid !== 1'b0) begin
            bad++;
            $display("FAIL depth1_hold: O=%h v=%b want c5/0", o1, o1_valid);
        end
    endtask

    initial begin
        ASYNCRESET = 1'b1;
        CE = 1'b0;
        CLR = 1'b0;
        I = '0;
        I_valid = 1'b0;
        #12;
        test_reset();
        test_latency();
        test_stall();
        test_bubbles();
        test_clear();
        test_depth1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
